gpio_irq_detect: RTL and testbench

Input-side GPIO conditioning stage that sits directly between the gecko_soc_top gpio_inout pads and the APB GPIO register file.
- Synchronises every pin into clk, applies a programmable glitch filter, and detects level-low, level-high, falling-edge and rising-edge events per pin.
- Holds per-pin sticky pending status and drives a single registered interrupt line to the event unit.
- Configuration and status clearing are driven by the register file.

---
 rtl/gpio_irq_detect.sv | 162 ++++++++++++++++
 tb/tb_gpio_irq_detect.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/gpio_irq_detect.sv
// gpio_irq_detect: input-side GPIO conditioning between the pads and the GPIO register file.
// Each pin is synchronised, glitch-filtered, then checked for level/edge events. Events
// set sticky pending bits, and the OR of those bits drives a registered interrupt line.
//
// Ports:
//   clk, rst_n      system clock, asynchronous active-low reset
//   gpio_in         raw pad inputs (asynchronous to clk)
//   filter_cycles   glitch filter length, shared by all pins
//   irq_en          per-pin interrupt enable
//   irq_type        per-pin type, 2 bits per pin:
//                   00 level low, 01 level high, 10 falling, 11 rising
//   clr_valid       one-cycle strobe that clears the status bits selected by clr_mask
//   clr_mask        status bits to clear
//   gpio_sync       filtered pin values
//   irq_status      sticky pending bits
//   irq_o           registered OR of irq_status
module gpio_irq_detect #(
    parameter int unsigned NUM_GPIO    = 32,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned FILTER_W    = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NUM_GPIO-1:0]   gpio_in,
    input  logic [FILTER_W-1:0]   filter_cycles,
    input  logic [NUM_GPIO-1:0]   irq_en,
    input  logic [2*NUM_GPIO-1:0] irq_type,
    input  logic                  clr_valid,
    input  logic [NUM_GPIO-1:0]   clr_mask,
    output logic [NUM_GPIO-1:0]   gpio_sync,
    output logic [NUM_GPIO-1:0]   irq_status,
    output logic                  irq_o
);

    typedef enum logic {StInit, StRun} state_e;

    // INIT runs for SYNC_STAGES+1 cycles: the counter walks 0..SYNC_STAGES.
    localparam logic [2:0] InitLast = 3'(SYNC_STAGES);

    state_e              r_state, w_state_next;
    logic [2:0]          r_init_cnt, w_init_cnt_next;
    logic [NUM_GPIO-1:0] r_sync [SYNC_STAGES];
    logic [NUM_GPIO-1:0] r_prev;
    logic [FILTER_W-1:0] r_cnt [NUM_GPIO];
    logic [FILTER_W-1:0] w_cnt_next [NUM_GPIO];
    logic [NUM_GPIO-1:0] w_sync;
    logic [NUM_GPIO-1:0] w_gpio_sync_next;
    logic [NUM_GPIO-1:0] w_prev_next;
    logic [NUM_GPIO-1:0] w_ev;
    logic [NUM_GPIO-1:0] w_set;
    logic [NUM_GPIO-1:0] w_clr;
    logic                w_init;

    assign w_sync = r_sync[SYNC_STAGES-1];
    assign w_init = (r_state == StInit);

    // Synchroniser chain
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned s = 0; s < SYNC_STAGES; s++) begin
                r_sync[s] <= '0;
            end
        end else begin
            r_sync[0] <= gpio_in;
            for (int unsigned s = 1; s < SYNC_STAGES; s++) begin
                r_sync[s] <= r_sync[s-1];
            end
        end
    end

    // Control FSM: state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= StInit;
            r_init_cnt <= '0;
        end else begin
            r_state    <= w_state_next;
            r_init_cnt <= w_init_cnt_next;
        end
    end

    // Control FSM: next state. RUN is only left through reset.
    always_comb begin
        w_state_next    = r_state;
        w_init_cnt_next = r_init_cnt;
        unique case (r_state)
            StInit: begin
                if (r_init_cnt == InitLast) begin
                    w_state_next = StRun;
                end else begin
                    w_init_cnt_next = r_init_cnt + 3'd1;
                end
            end
            StRun: begin
                w_state_next = StRun;
            end
        endcase
    end

    // Glitch filter and event selection
    always_comb begin
        w_gpio_sync_next = gpio_sync;
        w_prev_next      = gpio_sync;
        w_ev             = '0;
        for (int unsigned i = 0; i < NUM_GPIO; i++) begin
            w_cnt_next[i] = r_cnt[i];
        end

        if (w_init) begin
            // Preload from the synchroniser so idle pad levels never look like edges.
            w_gpio_sync_next = w_sync;
            w_prev_next      = w_sync;
            for (int unsigned i = 0; i < NUM_GPIO; i++) begin
                w_cnt_next[i] = '0;
            end
        end else begin
            for (int unsigned i = 0; i < NUM_GPIO; i++) begin
                if (w_sync[i] == gpio_sync[i]) begin
                    w_cnt_next[i] = '0;
                end else if (r_cnt[i] == filter_cycles) begin
                    w_gpio_sync_next[i] = w_sync[i];
                    w_cnt_next[i]       = '0;
                end else begin
                    w_cnt_next[i] = r_cnt[i] + 1'b1;
                end

                unique case (irq_type[2*i +: 2])
                    2'b00: w_ev[i] = ~gpio_sync[i];
                    2'b01: w_ev[i] = gpio_sync[i];
                    2'b10: w_ev[i] = r_prev[i] & ~gpio_sync[i];
                    2'b11: w_ev[i] = ~r_prev[i] & gpio_sync[i];
                endcase
            end
        end
    end

    assign w_set = w_ev & irq_en;
    assign w_clr = clr_valid ? clr_mask : '0;

    // Pin state, filter counters, status and interrupt
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gpio_sync  <= '0;
            r_prev     <= '0;
            irq_status <= '0;
            irq_o      <= 1'b0;
            for (int unsigned i = 0; i < NUM_GPIO; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            gpio_sync  <= w_gpio_sync_next;
            r_prev     <= w_prev_next;
            // Set is OR-ed last so it wins over a clear on the same bit.
            irq_status <= (irq_status & ~w_clr) | w_set;
            irq_o      <= |irq_status;
            for (int unsigned i = 0; i < NUM_GPIO; i++) begin
                r_cnt[i] <= w_cnt_next[i];
            end
        end
    end

endmodule

// File: tb/tb_gpio_irq_detect.sv
// Directed self-checking bench for gpio_irq_detect (NUM_GPIO=32, SYNC_STAGES=2, FILTER_W=4).
// Inputs change 1 time unit after a rising edge; outputs are sampled at the same point.
module tb_gpio_irq_detect;

    logic        clk;
    logic        rst_n;
    logic [31:0] gpio_in;
    logic [3:0]  filter_cycles;
    logic [31:0] irq_en;
    logic [63:0] irq_type;
    logic        clr_valid;
    logic [31:0] clr_mask;
    logic [31:0] gpio_sync;
    logic [31:0] irq_status;
    logic        irq_o;

    int n_pass  = 0;
    int n_total = 0;

    gpio_irq_detect #(
        .NUM_GPIO    (32),
        .SYNC_STAGES (2),
        .FILTER_W    (4)
    ) u_dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .gpio_in       (gpio_in),
        .filter_cycles (filter_cycles),
        .irq_en        (irq_en),
        .irq_type      (irq_type),
        .clr_valid     (clr_valid),
        .clr_mask      (clr_mask),
        .gpio_sync     (gpio_sync),
        .irq_status    (irq_status),
        .irq_o         (irq_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    initial begin
        logic [31:0] pads;
        logic [32:0] m33;

        rst_n         = 1'b0;
        gpio_in       = 32'hAAAA_AAAA;
        filter_cycles = 4'd0;
        irq_en        = '1;
        irq_type      = '1;
        clr_valid     = 1'b0;
        clr_mask      = '0;
        #1;
        check("rst_gpio_sync", gpio_sync, 32'h0);
        check("rst_status", irq_status, 32'h0);
        check("rst_irq_o", {31'h0, irq_o}, 32'h0);

        // 1: reset release with arbitrary idle levels, rising type everywhere
        tick(2);
        rst_n = 1'b1;
        tick(1);
        check("t1_init_sync", gpio_sync, 32'h0);
        check("t1_init_status", irq_status, 32'h0);
        tick(2);
        check("t1_sync_loaded", gpio_sync, 32'hAAAA_AAAA);
        tick(5);
        check("t1_status_quiet", irq_status, 32'h0);
        check("t1_irq_quiet", {31'h0, irq_o}, 32'h0);
        check("t1_sync_hold", gpio_sync, 32'hAAAA_AAAA);

        // 2: glitch filter, length 3
        filter_cycles = 4'd3;
        gpio_in = 32'hAAAA_AAAB;
        tick(3);
        gpio_in = 32'hAAAA_AAAA;
        tick(8);
        check("t2_short_sync", gpio_sync, 32'hAAAA_AAAA);
        check("t2_short_status", irq_status, 32'h0);
        gpio_in = 32'hAAAA_AAAB;
        tick(4);
        gpio_in = 32'hAAAA_AAAA;
        tick(1);
        check("t2_edge5_sync", gpio_sync, 32'hAAAA_AAAA);
        tick(1);
        check("t2_edge6_sync", gpio_sync, 32'hAAAA_AAAB);
        tick(1);
        check("t2_rise_status", irq_status, 32'h1);
        check("t2_irq_lag", {31'h0, irq_o}, 32'h0);
        tick(1);
        check("t2_irq_set", {31'h0, irq_o}, 32'h1);
        tick(6);
        check("t2_fall_sync", gpio_sync, 32'hAAAA_AAAA);
        clr_valid = 1'b1;
        clr_mask  = '1;
        tick(1);
        clr_valid = 1'b0;
        check("t2_cleared", irq_status, 32'h0);

        // 3: level low
        filter_cycles = 4'd0;
        gpio_in = 32'h0;
        tick(5);
        check("t3_sync_low", gpio_sync, 32'h0);
        check("t3_no_rise", irq_status, 32'h0);
        irq_type = '0;
        tick(1);
        check("t3_level_status", irq_status, 32'hFFFF_FFFF);
        check("t3_irq_lag", {31'h0, irq_o}, 32'h0);
        tick(1);
        check("t3_irq_set", {31'h0, irq_o}, 32'h1);
        clr_valid = 1'b1;
        clr_mask  = '1;
        tick(1);
        clr_valid = 1'b0;
        check("t3_clr_while_low", irq_status, 32'hFFFF_FFFF);
        gpio_in = '1;
        tick(5);
        check("t3_sync_high", gpio_sync, 32'hFFFF_FFFF);
        check("t3_sticky", irq_status, 32'hFFFF_FFFF);
        clr_valid = 1'b1;
        tick(1);
        clr_valid = 1'b0;
        check("t3_clr_status", irq_status, 32'h0);
        check("t3_irq_still", {31'h0, irq_o}, 32'h1);
        tick(1);
        check("t3_irq_clr", {31'h0, irq_o}, 32'h0);

        // 4: falling edge, one pin at a time
        irq_type = {32{2'b10}};
        tick(1);
        check("t4_start", irq_status, 32'h0);
        pads = '1;
        for (int k = 0; k < 32; k++) begin
            pads[k] = 1'b0;
            gpio_in = pads;
            tick(4);
            m33 = (33'd1 << (k + 1)) - 33'd1;
            check($sformatf("t4_fall_pin%0d", k), irq_status, m33[31:0]);
        end

        // 5: rising edge with partial enable, set beats clear
        clr_valid = 1'b1;
        clr_mask  = '1;
        tick(1);
        clr_valid = 1'b0;
        check("t5_start", irq_status, 32'h0);
        irq_type = '1;
        irq_en   = 32'h0000_FFFF;
        gpio_in  = '1;
        tick(4);
        check("t5_rise_en", irq_status, 32'h0000_FFFF);
        gpio_in = 32'hFFFF_FFFE;
        tick(4);
        gpio_in = '1;
        tick(3);
        clr_valid = 1'b1;
        clr_mask  = 32'h1;
        tick(1);
        clr_valid = 1'b0;
        check("t5_set_wins", irq_status, 32'h0000_FFFF);
        clr_valid = 1'b1;
        clr_mask  = 32'h2;
        tick(1);
        clr_valid = 1'b0;
        check("t5_clr_bit1", irq_status, 32'h0000_FFFD);

        // 6: reset mid-run
        clr_valid = 1'b1;
        clr_mask  = '1;
        tick(1);
        clr_valid = 1'b0;
        irq_en    = 32'hFFFF_0000;
        irq_type  = {32{2'b01}};
        tick(1);
        check("t6_status", irq_status, 32'hFFFF_0000);
        rst_n = 1'b0;
        #1;
        check("t6_rst_sync", gpio_sync, 32'h0);
        check("t6_rst_status", irq_status, 32'h0);
        check("t6_rst_irq", {31'h0, irq_o}, 32'h0);
        tick(1);
        rst_n = 1'b1;
        tick(1);
        check("t6_init1_status", irq_status, 32'h0);
        tick(1);
        check("t6_init2_status", irq_status, 32'h0);
        tick(1);
        check("t6_init3_status", irq_status, 32'h0);
        check("t6_init3_sync", gpio_sync, 32'hFFFF_FFFF);
        check("t6_init3_irq", {31'h0, irq_o}, 32'h0);
        tick(1);
        check("t6_run_status", irq_status, 32'hFFFF_0000);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
